// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand-issue stage feeding the ALU. Holds the architectural register file
//   and a per-register busy scoreboard. It accepts ops over valid/ready, reads
//   or forwards the operands, and presents a registered {f, a, b, rd} to the
//   ALU. ALU results return through the write-back port.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid / in_ready          upstream op handshake
//   in_f, in_ra, in_rb, in_rd    function code, source and destination registers
//   in_use_imm, in_imm           select immediate as operand B
//   out_valid / out_ready        downstream (ALU) handshake
//   out_f, out_a, out_b, out_rd  registered op presented to the ALU
//   wb_en, wb_rd, wb_data        write-back of ALU result (never back-pressured)

module alu_operand_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_f,
    input  logic [AW-1:0]    in_ra,
    input  logic [AW-1:0]    in_rb,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_f,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [AW-1:0]    out_rd,

    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data
);

    localparam int unsigned NumRegs = 2 ** AW;

    logic [WIDTH-1:0] regs_q [NumRegs];
    logic [WIDTH-1:0] regs_d [NumRegs];
    logic [NumRegs-1:0] busy_q, busy_d;

    logic             out_valid_q, out_valid_d;
    logic [2:0]       out_f_q, out_f_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [AW-1:0]    out_rd_q, out_rd_d;

    logic             wb_write;
    logic             fwd_a, fwd_b;
    logic             busy_a, busy_b;
    logic             hazard, slot_free, accept;
    logic [WIDTH-1:0] opnd_a, opnd_b;

    // Operand read / forward and the issue condition.
    always_comb begin
        wb_write  = wb_en && (wb_rd != '0);
        fwd_a     = wb_en && (wb_rd == in_ra) && (in_ra != '0);
        fwd_b     = wb_en && (wb_rd == in_rb) && (in_rb != '0);

        // Register 0 is never busy; masked here as well as never being set.
        busy_a    = busy_q[in_ra] && (in_ra != '0);
        busy_b    = busy_q[in_rb] && (in_rb != '0);

        opnd_a    = '0;
        if (fwd_a) begin
            opnd_a = wb_data;
        end else if (in_ra != '0) begin
            opnd_a = regs_q[in_ra];
        end

        opnd_b    = '0;
        if (in_use_imm) begin
            opnd_b = in_imm;
        end else if (fwd_b) begin
            opnd_b = wb_data;
        end else if (in_rb != '0) begin
            opnd_b = regs_q[in_rb];
        end

        hazard    = (busy_a && !fwd_a) || (!in_use_imm && busy_b && !fwd_b);
        slot_free = !out_valid_q || out_ready;
        in_ready  = slot_free && !hazard;
        accept    = in_valid && in_ready;
    end

    // Register file and scoreboard next state.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;

        if (wb_write) begin
            regs_d[wb_rd] = wb_data;
            busy_d[wb_rd] = 1'b0;
        end

        // Applied after the write-back clear so a same-cycle set wins.
        if (accept && (in_rd != '0)) begin
            busy_d[in_rd] = 1'b1;
        end
    end

    // Output slot next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_f_d     = out_f_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_rd_d    = out_rd_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_f_d     = in_f;
            out_a_d     = opnd_a;
            out_b_d     = opnd_b;
            out_rd_d    = in_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes expected {f, a, b, rd}
// on accept, a monitor pops and compares whenever the ALU side consumes an op.

module tb_alu_operand_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_f;
    logic [AW-1:0]    in_ra, in_rb, in_rd;
    logic             in_use_imm;
    logic [WIDTH-1:0] in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_f;
    logic [WIDTH-1:0] out_a, out_b;
    logic [AW-1:0]    out_rd;
    logic             wb_en;
    logic [AW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [71:0] sb [$];

    alu_operand_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_f       (in_f),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_rd      (in_rd),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every op the ALU side consumes against the scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {out_f, out_a, out_b, out_rd}, 72'h0);
            end else begin
                check("out_op", {out_f, out_a, out_b, out_rd}, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [AW-1:0] rd, input logic [WIDTH-1:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] f, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                          input logic [AW-1:0] rd, input logic use_imm,
                          input logic [WIDTH-1:0] imm);
        in_f       = f;
        in_ra      = ra;
        in_rb      = rb;
        in_rd      = rd;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_valid   = 1'b1;
    endtask

    // Present an op, wait (bounded) for in_ready, push its expected image.
    task automatic issue(input logic [2:0] f, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [AW-1:0] rd, input logic use_imm,
                         input logic [WIDTH-1:0] imm,
                         input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_b);
        int n = 0;
        set_op(f, ra, rb, rd, use_imm, imm);
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_accept", {71'h0, in_ready}, 72'h1);
        if (in_ready) sb.push_back({f, exp_a, exp_b, rd});
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_f       = '0;
        in_ra      = '0;
        in_rb      = '0;
        in_rd      = '0;
        in_use_imm = 1'b0;
        in_imm     = '0;
        out_ready  = 1'b1;
        wb_en      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset: preload registers, hold an op, then reset asynchronously.
        for (int i = 1; i < 32; i++) do_wb(AW'(i), 32'h0101_0101 * i);
        out_ready = 1'b0;
        issue(3'd7, 5'd1, 5'd2, 5'd9, 1'b0, '0, 32'h0101_0101, 32'h0202_0202);
        @(negedge clk);
        check("held_valid", {71'h0, out_valid}, 72'h1);
        check("held_a", {40'h0, out_a}, {40'h0, 32'h0101_0101});
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_valid", {71'h0, out_valid}, 72'h0);
        check("rst_out", {out_f, out_a, out_b, out_rd}, 72'h0);
        sb.delete();
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 1; i < 32; i++) issue(3'd0, AW'(i), AW'(i), 5'd0, 1'b0, '0, '0, '0);

        // Basic issue.
        do_wb(5'd1, 32'h0000_0005);
        do_wb(5'd2, 32'h0000_0003);
        tick();
        issue(3'd2, 5'd1, 5'd2, 5'd3, 1'b0, '0, 32'h5, 32'h3);

        // Stall on busy r3, released by a forwarded write-back.
        set_op(3'd1, 5'd3, 5'd0, 5'd5, 1'b0, '0);
        @(negedge clk);
        check("stall_r3_0", {71'h0, in_ready}, 72'h0);
        tick();
        @(negedge clk);
        check("stall_r3_1", {71'h0, in_ready}, 72'h0);
        tick();
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h8;
        @(negedge clk);
        check("fwd_r3_ready", {71'h0, in_ready}, 72'h1);
        if (in_ready) sb.push_back({3'd1, 32'h8, 32'h0, 5'd5});
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fwd_r3_a", {40'h0, out_a}, {40'h0, 32'h8});

        // WAW on busy r5 is accepted; r5 stays busy until its write-back.
        tick();
        issue(3'd0, 5'd1, 5'd2, 5'd5, 1'b0, '0, 32'h5, 32'h3);
        set_op(3'd6, 5'd5, 5'd5, 5'd6, 1'b0, '0);
        @(negedge clk);
        check("waw_busy", {71'h0, in_ready}, 72'h0);
        tick();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        @(negedge clk);
        check("fwd_ab_ready", {71'h0, in_ready}, 72'h1);
        if (in_ready) sb.push_back({3'd6, 32'h55, 32'h55, 5'd6});
        tick();
        wb_en = 1'b0; in_valid = 1'b0;

        // Self-referencing op: rd == ra reads old value without stalling.
        do_wb(5'd6, 32'h66);
        issue(3'd4, 5'd6, 5'd0, 5'd6, 1'b1, 32'h8000_0000, 32'h66, 32'h8000_0000);

        // Back-pressure: drain, then hold out_ready low with a second op waiting.
        tick();
        out_ready = 1'b0;
        issue(3'd1, 5'd1, 5'd2, 5'd0, 1'b0, '0, 32'h5, 32'h3);
        set_op(3'd4, 5'd2, 5'd1, 5'd0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", {71'h0, in_ready}, 72'h0);
            check("bp_stable", {out_f, out_a, out_b, out_rd}, {3'd1, 32'h5, 32'h3, 5'd0});
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {71'h0, in_ready}, 72'h1);
        if (in_ready) sb.push_back({3'd4, 32'h3, 32'h5, 5'd0});
        tick();
        in_valid = 1'b0;

        // Register 0: write ignored, immediate passes through, no busy set.
        do_wb(5'd0, 32'hFFFF_FFFF);
        issue(3'd3, 5'd0, 5'd7, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
        set_op(3'd2, 5'd0, 5'd0, 5'd0, 1'b0, '0);
        @(negedge clk);
        check("r0_no_stall", {71'h0, in_ready}, 72'h1);
        if (in_ready) sb.push_back({3'd2, 32'h0, 32'h0, 5'd0});
        tick();
        in_valid = 1'b0;

        // Set-vs-clear collision on r4: set wins.
        set_op(3'd5, 5'd1, 5'd2, 5'd4, 1'b0, '0);
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h11;
        @(negedge clk);
        check("coll_ready", {71'h0, in_ready}, 72'h1);
        if (in_ready) sb.push_back({3'd5, 32'h5, 32'h3, 5'd4});
        tick();
        wb_en = 1'b0;
        set_op(3'd0, 5'd4, 5'd0, 5'd0, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("coll_stall", {71'h0, in_ready}, 72'h0);
            tick();
        end
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h22;
        @(negedge clk);
        check("coll_release", {71'h0, in_ready}, 72'h1);
        if (in_ready) sb.push_back({3'd0, 32'h22, 32'h0, 5'd0});
        tick();
        wb_en = 1'b0; in_valid = 1'b0;

        repeat (3) tick();
        check("sb_empty", 72'(sb.size()), 72'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-issue stage directly upstream of the alu (a, b, f inputs; y, zero outputs).
- Holds the architectural register file and a per-register busy scoreboard.
- Accepts ops over valid/ready, reads or forwards operands, and presents a registered {f, a, b, rd} to the ALU.
- Takes ALU results back through a write-back port.

Parameters:
WIDTH, 32, datapath and register width
AW, 5, register address width (2**AW registers; register 0 hardwired to zero)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept op this cycle
in_f  input  3  ALU function code, passed through unchanged
in_ra  input  AW  source register A
in_rb  input  AW  source register B
in_rd  input  AW  destination register
in_use_imm  input  1  1: operand B = in_imm, in_rb ignored
in_imm  input  WIDTH  immediate operand
out_valid  output  1  op presented to ALU
out_ready  input  1  ALU side consumes op this cycle
out_f  output  3  to alu f
out_a  output  WIDTH  to alu a
out_b  output  WIDTH  to alu b
out_rd  output  AW  destination tag travelling with the op
wb_en  input  1  write-back strobe
wb_rd  input  AW  write-back register
wb_data  input  WIDTH  write-back value (alu y)

Behaviour:
- Reset (async, reset_n=0): all registers = 0, all busy bits = 0, out_valid = 0, out_f/out_a/out_b/out_rd = 0. Reset mid-operation discards the held op and all pending scoreboard state. No write occurs on the edge reset is released if reset_n is still low.
- Accept condition: in_valid && in_ready.
- in_ready = slot_free && !hazard.
  - slot_free = !out_valid || out_ready.
  - hazard = (busy[in_ra] && !fwd_a) || (!in_use_imm && busy[in_rb] && !fwd_b).
  - Register 0 is never busy.
- Forwarding: fwd_a = wb_en && wb_rd == in_ra && in_ra != 0; fwd_b is the same for in_rb.
  - Forwarded operand = wb_data; otherwise operand = regfile read.
  - Reads of register 0 = 0.
- Latency: an op accepted in cycle N appears on out_* with out_valid=1 from cycle N+1.
  - Held stable while out_valid && !out_ready.
  - Out slot cleared (out_valid=0) when out_ready && no new accept.
  - Accept and drain in the same cycle gives back-to-back issue at full throughput.
- out_b = in_imm when in_use_imm, else operand B.
- out_f and out_rd are registered copies of in_f and in_rd.
- Write-back: when wb_en && wb_rd != 0, register[wb_rd] <= wb_data and busy[wb_rd] <= 0.
  - wb_rd == 0 is ignored entirely.
  - wb_en is never back-pressured.
- Scoreboard: on accept with in_rd != 0, busy[in_rd] <= 1.
  - Same-cycle accept setting busy[r] and write-back clearing busy[r]: set wins. The register value still updates.
- Op with in_rd == in_ra (e.g. r3 = r3 + 1) reads the old value before marking busy. No self-stall.
- Second op to a busy rd (WAW) with no source hazard is accepted. Busy stays 1, and the first write-back clears it. Upstream guarantees in-order write-back; the stage does not track a count.
- in_valid=0: no state change except write-back and out-slot drain.
- Arithmetic: none in this stage. Widths pass through exactly; no sign extension of in_imm.

Test Plan:
- Reset: assert reset_n=0 mid-stream with out_valid=1 -> out_valid=0 and out_* = 0 immediately (asynchronous). After release, reading r1..r31 yields 0.
- Basic issue: wb r1=0x00000005 and r2=0x00000003, wait, then issue f=2, ra=1, rb=2, rd=3 -> next cycle out_a=0x5, out_b=0x3, out_f=2, out_rd=3, out_valid=1.
- Stall and forward: issue rd=3 with out_ready=1, then op ra=3 -> in_ready=0 while busy[3]. In the cycle wb_en=1, wb_rd=3, wb_data=0x00000008: in_ready=1 and out_a=0x8 next cycle.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable. When out_ready=1, the new op is accepted the same cycle and out_* updates the next cycle.
- Register 0: wb r0=0xFFFFFFFF, issue ra=0, rd=0, use_imm=1, imm=0xDEADBEEF -> out_a=0, out_b=0xDEADBEEF, no busy set, the next op reading r0 is not stalled.
- Set-vs-clear collision: accept rd=4 in the same cycle as wb rd=4, data 0x11 -> busy[4]=1 afterwards, register 4 = 0x11, and an op reading r4 stalls until the next wb to r4.
